// File: rtl/cordic_pkg.sv
// Shared widths, angle constants, FSM encoding and saturating arithmetic
// for the rotation-mode CORDIC sequencer.
package cordic_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 17;
    localparam int CNT_W  = 5;

    localparam logic signed [DATA_W-1:0] PI_Q13      = 16'sd25736;
    localparam logic signed [DATA_W-1:0] HALF_PI_Q13 = 16'sd12868;
    localparam logic signed [DATA_W-1:0] K_INIT_DEF  = 16'sd9949;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // a +/- b in a 17-bit intermediate, clipped back into 16-bit two's complement
    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic                     sub
    );
        logic signed [ACC_W-1:0] ae;
        logic signed [ACC_W-1:0] be;
        logic signed [ACC_W-1:0] s;
        ae = {a[DATA_W-1], a};
        be = {b[DATA_W-1], b};
        s  = sub ? (ae - be) : (ae + be);
        if (!s[ACC_W-1] && s[ACC_W-2])
            return 16'sh7fff;
        else if (s[ACC_W-1] && !s[ACC_W-2])
            return 16'sh8000;
        else
            return s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent table atan(2^-i) in Q2.13, indexed by the iteration counter.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [3:0]               idx,
    output logic signed [DATA_W-1:0] atan
);

    always_comb begin
        atan = '0;
        case (idx)
            4'd0:  atan = 16'sd6434;
            4'd1:  atan = 16'sd3798;
            4'd2:  atan = 16'sd2007;
            4'd3:  atan = 16'sd1019;
            4'd4:  atan = 16'sd511;
            4'd5:  atan = 16'sd256;
            4'd6:  atan = 16'sd128;
            4'd7:  atan = 16'sd64;
            4'd8:  atan = 16'sd32;
            4'd9:  atan = 16'sd16;
            4'd10: atan = 16'sd8;
            4'd11: atan = 16'sd4;
            4'd12: atan = 16'sd2;
            4'd13: atan = 16'sd1;
            default: atan = 16'sd0;
        endcase
    end

endmodule

// File: rtl/cordic_rotation_seq.sv
// Iterative rotation-mode CORDIC: angle in over valid/ready, cos/sin out over valid/ready.
// Define CORDIC_QUAD_EXT_EN to accept the full +/-pi input range via a half-turn fold.
module cordic_rotation_seq
    import cordic_pkg::*;
#(
    parameter int                       ITER   = 16,
    parameter logic signed [DATA_W-1:0] K_INIT = K_INIT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] angle_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] cos_o,
    output logic signed [DATA_W-1:0] sin_o
);

    localparam logic [CNT_W-1:0] ITER_C = CNT_W'(ITER);

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] x, y, z;
    logic [CNT_W-1:0]         cnt;
    logic                     neg;

    logic load, iter_en, finish;
    logic signed [DATA_W-1:0] atan;
    logic signed [DATA_W-1:0] x_sh, y_sh;
    logic signed [DATA_W-1:0] x_nxt, y_nxt, z_nxt;
    logic signed [DATA_W-1:0] z_load;
    logic                     neg_load;
    logic                     d;

    cordic_atan_rom u_atan_rom (
        .idx  (cnt[3:0]),
        .atan (atan)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        load      = 1'b0;
        iter_en   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // the extra cycle at cnt==ITER registers the (possibly negated) result
                if (cnt == ITER_C) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    iter_en = 1'b1;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef CORDIC_QUAD_EXT_EN
    always_comb begin
        z_load   = angle_i;
        neg_load = 1'b0;
        if (angle_i > HALF_PI_Q13) begin
            z_load   = sat_add((angle_i > PI_Q13) ? PI_Q13 : angle_i, PI_Q13, 1'b1);
            neg_load = 1'b1;
        end else if (angle_i < -HALF_PI_Q13) begin
            z_load   = sat_add((angle_i < -PI_Q13) ? -PI_Q13 : angle_i, PI_Q13, 1'b0);
            neg_load = 1'b1;
        end
    end
`else
    always_comb begin
        z_load   = angle_i;
        neg_load = 1'b0;
        if (angle_i > HALF_PI_Q13)
            z_load = HALF_PI_Q13;
        else if (angle_i < -HALF_PI_Q13)
            z_load = -HALF_PI_Q13;
    end
`endif

    always_comb begin
        d     = !z[DATA_W-1];
        x_sh  = x >>> cnt[3:0];
        y_sh  = y >>> cnt[3:0];
        x_nxt = sat_add(x, y_sh, d);
        y_nxt = sat_add(y, x_sh, !d);
        z_nxt = sat_add(z, atan, d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            cos_o     <= '0;
            sin_o     <= '0;
        end else begin
            if (load) begin
                x   <= K_INIT;
                y   <= '0;
                z   <= z_load;
                cnt <= '0;
                neg <= neg_load;
            end else if (iter_en) begin
                x   <= x_nxt;
                y   <= y_nxt;
                z   <= z_nxt;
                cnt <= cnt + 1'b1;
            end

            if (finish) begin
                out_valid <= 1'b1;
                cos_o     <= neg ? sat_add('0, x, 1'b1) : x;
                sin_o     <= neg ? sat_add('0, y, 1'b1) : y;
            end else if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cordic_rotation_seq.sv
// Self-checking bench: real-valued cos/sin reference, per-cycle scoreboard, directed vectors.
module tb_cordic_rotation_seq;

    localparam int ITER = 16;
    localparam int TOL  = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [15:0] angle_i = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] cos_o;
    logic signed [15:0] sin_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cordic_rotation_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_i   (angle_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_o     (cos_o),
        .sin_o     (sin_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        total++;
        if (act > exp + tol || act < exp - tol) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    function automatic int clamp_angle(input int a);
`ifdef CORDIC_QUAD_EXT_EN
        int lim = 25736;
`else
        int lim = 12868;
`endif
        if (a > lim) return lim;
        if (a < -lim) return -lim;
        return a;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int model_cos(input int a);
        return rnd(16384.0 * $cos(real'(clamp_angle(a)) / 8192.0));
    endfunction

    function automatic int model_sin(input int a);
        return rnd(16384.0 * $sin(real'(clamp_angle(a)) / 8192.0));
    endfunction

    // scoreboard: accepted angles and the edge on which each was accepted
    int exp_q[$];
    int hs_q[$];
    bit was_valid = 1'b0;
    int prev_cos, prev_sin;
    int last_cos, last_sin;
    int results = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hs_q.delete();
            was_valid = 1'b0;
            chk("in_ready_in_rst", int'(in_ready), 0, 0);
        end else begin
            chk("in_ready", int'(in_ready), (exp_q.size() == 0) ? 1 : 0, 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0, 0);
                end else if (!was_valid) begin
                    chk("latency", cyc - hs_q[0], ITER + 1, 0);
                    chk("cos_model", int'(cos_o), model_cos(exp_q[0]), TOL);
                    chk("sin_model", int'(sin_o), model_sin(exp_q[0]), TOL);
                    last_cos = cos_o;
                    last_sin = sin_o;
                    results++;
                end else begin
                    chk("hold_cos", int'(cos_o), prev_cos, 0);
                    chk("hold_sin", int'(sin_o), prev_sin, 0);
                end
                prev_cos = cos_o;
                prev_sin = sin_o;
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(hs_q.pop_front());
                    was_valid = 1'b0;
                end else begin
                    was_valid = 1'b1;
                end
            end else begin
                if (was_valid) chk("out_valid_dropped", 0, 1, 0);
                was_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(int'(angle_i));
                hs_q.push_back(cyc + 1);
            end
        end
    end

    task automatic send(input int a);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        angle_i  = 16'(a);
        n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int r0);
        int n;
        n = 0;
        while (results == r0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (results == r0) chk("result_timeout", 0, 1, 0);
        #1;
    endtask

    task automatic run(input int a, input int ec, input int es);
        int r0;
        r0 = results;
        send(a);
        wait_result(r0);
        chk("cos_literal", last_cos, ec, TOL);
        chk("sin_literal", last_sin, es, TOL);
        @(posedge clk); #1;
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_cos", int'(cos_o), 0, 0);
        chk("rst_sin", int'(sin_o), 0, 0);
        chk("rst_in_ready", int'(in_ready), 0, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1, 0);
        out_ready = 1'b1;

        run(0, 16384, 0);
        run(6434, 11585, 11585);
        run(-6434, 11585, -11585);
        run(12868, 0, 16384);
        run(3217, 15137, 6270);
`ifdef CORDIC_QUAD_EXT_EN
        run(25736, -16384, 0);
        run(19302, -11585, 11585);
        run(-19302, -11585, -11585);
        run(-25736, -16384, 0);
        run(30000, -16384, 0);
`else
        run(20000, 0, 16384);
        run(-20000, 0, -16384);
        run(-12868, 0, -16384);
`endif

        // backpressure: result held, in_valid pulse ignored
        out_ready = 1'b0;
        r0 = results;
        send(9000);
        wait_result(r0);
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        angle_i  = 16'sd1000;
        chk("bp_in_ready", int'(in_ready), 0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("bp_out_valid", int'(out_valid), 1, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", int'(out_valid), 0, 0);
        chk("bp_release_ready", int'(in_ready), 1, 0);

        // reset in the middle of the iterations
        send(6434);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrun_rst_valid", int'(out_valid), 0, 0);
        chk("midrun_rst_cos", int'(cos_o), 0, 0);
        chk("midrun_rst_sin", int'(sin_o), 0, 0);
        rst = 1'b0;
        #1;
        chk("midrun_rel_ready", int'(in_ready), 1, 0);
        run(6434, 11585, 11585);

        // reset while a result is pending
        out_ready = 1'b0;
        r0 = results;
        send(-3217);
        wait_result(r0);
        chk("done_cos", last_cos, 15137, TOL);
        chk("done_sin", last_sin, -6270, TOL);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("done_rst_valid", int'(out_valid), 0, 0);
        chk("done_rst_cos", int'(cos_o), 0, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        run(0, 16384, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
